// File: rtl/mul_pkg.sv
// Shared encodings and constants for the multi-cycle RV32M multiply sequencer.
package mul_pkg;
  localparam int CALC_STEPS = 4;

  localparam logic [1:0] MUL_OP_MUL    = 2'b00;
  localparam logic [1:0] MUL_OP_MULH   = 2'b01;
  localparam logic [1:0] MUL_OP_MULHSU = 2'b10;
  localparam logic [1:0] MUL_OP_MULHU  = 2'b11;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic op_a_signed(input logic [1:0] op);
    return (op == MUL_OP_MULH) || (op == MUL_OP_MULHSU);
  endfunction

  function automatic logic op_b_signed(input logic [1:0] op);
    return op == MUL_OP_MULH;
  endfunction
endpackage

// File: rtl/mul_seq_ctrl_if.sv
// Request/response handshake bundle between EX, writeback and the multiply sequencer.
interface mul_seq_ctrl_if #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [XLEN-1:0]  req_a;
  logic [XLEN-1:0]  req_b;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             resp_valid;
  logic             resp_ready;
  logic [XLEN-1:0]  resp_data;
  logic [TAG_W-1:0] resp_tag;
  logic             busy;

  modport master (
    output req_valid, req_op, req_a, req_b, req_tag, flush, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag, busy
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, req_tag, flush, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag, busy
  );
endinterface

// File: rtl/mul16_u.sv
// Unsigned 16x16 -> 32 combinational multiplier, shared across all CALC steps.
module mul16_u (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [31:0] p
);
  assign p = 32'(a) * 32'(b);
endmodule

// File: rtl/mul_seq_ctrl.sv
// Four-cycle RV32M multiply sequencer: sign-magnitude operands, one 16x16 partial product per cycle.
// Optional MUL_ZERO_BYPASS_EN: a zero operand magnitude finishes after a single CALC cycle.
module mul_seq_ctrl
  import mul_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int TAG_W = 5
) (
  input logic           clk,
  input logic           rst_n,
  mul_seq_ctrl_if.slave bus
);
  localparam int HALF = XLEN / 2;
  localparam int CW   = $clog2(CALC_STEPS);
  localparam logic [CW-1:0] LAST = CW'(CALC_STEPS - 1);

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q;
  logic [2*XLEN-1:0] acc_q, acc_sum, pp_ext;
  logic [XLEN-1:0]   a_mag_q, b_mag_q, a_mag, b_mag, pp;
  logic [HALF-1:0]   x, y;
  logic [1:0]        op_q;
  logic [TAG_W-1:0]  tag_q;
  logic              neg_q, a_neg, b_neg, accept, last_step;
`ifdef MUL_ZERO_BYPASS_EN
  logic              zero_q;
`endif

  assign accept = (state_q == IDLE) && bus.req_valid && !bus.flush;
  assign a_neg  = op_a_signed(bus.req_op) & bus.req_a[XLEN-1];
  assign b_neg  = op_b_signed(bus.req_op) & bus.req_b[XLEN-1];
  assign a_mag  = a_neg ? -bus.req_a : bus.req_a;
  assign b_mag  = b_neg ? -bus.req_b : bus.req_b;

  // cnt bit1 picks the high half of a, bit0 the high half of b
  assign x = cnt_q[1] ? a_mag_q[XLEN-1:HALF] : a_mag_q[HALF-1:0];
  assign y = cnt_q[0] ? b_mag_q[XLEN-1:HALF] : b_mag_q[HALF-1:0];

  mul16_u u_mul (.a(x), .b(y), .p(pp));

  always_comb begin
    pp_ext = {{HALF{1'b0}}, pp, {HALF{1'b0}}};
    if (cnt_q == '0)  pp_ext = {{XLEN{1'b0}}, pp};
    if (cnt_q == LAST) pp_ext = {pp, {XLEN{1'b0}}};
  end

  assign acc_sum = acc_q + pp_ext;
`ifdef MUL_ZERO_BYPASS_EN
  assign last_step = (cnt_q == LAST) || zero_q;
`else
  assign last_step = (cnt_q == LAST);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = CALC;
      CALC:    if (bus.flush) state_d = IDLE;
               else if (last_step) state_d = DONE;
      DONE:    if (bus.flush || bus.resp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready  = (state_q == IDLE);
    bus.resp_valid = (state_q == DONE);
    bus.busy       = (state_q != IDLE);
    bus.resp_data  = '0;
    bus.resp_tag   = '0;
    if (state_q == DONE) begin
      bus.resp_data = (op_q == MUL_OP_MUL) ? acc_q[XLEN-1:0] : acc_q[2*XLEN-1:XLEN];
      bus.resp_tag  = tag_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      a_mag_q <= '0;
      b_mag_q <= '0;
      neg_q   <= 1'b0;
      op_q    <= MUL_OP_MUL;
      tag_q   <= '0;
`ifdef MUL_ZERO_BYPASS_EN
      zero_q  <= 1'b0;
`endif
    end else if (accept) begin
      cnt_q   <= '0;
      acc_q   <= '0;
      a_mag_q <= a_mag;
      b_mag_q <= b_mag;
      neg_q   <= a_neg ^ b_neg;
      op_q    <= bus.req_op;
      tag_q   <= bus.req_tag;
`ifdef MUL_ZERO_BYPASS_EN
      zero_q  <= (a_mag == '0) || (b_mag == '0);
`endif
    end else if (state_q == CALC && !bus.flush) begin
      cnt_q <= cnt_q + 1'b1;
      // sign is applied once to the full 64-bit sum on the final step
      acc_q <= (last_step && neg_q) ? -acc_sum : acc_sum;
    end
  end
endmodule

// File: doc/mul_seq_ctrl.md
Name: mul_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV32M multiply instructions MUL, MULH, MULHSU and MULHU.
- Sits beside the EX stage and computes the full 64-bit product by accumulating four 16x16 unsigned partial products over four cycles.
- Returns the selected 32-bit half to writeback through a valid/ready handshake.
- Drives `busy` so the hazard unit can stall issue.

Parameters:
- XLEN, 32, operand and result width; only 32 is supported.
- TAG_W, 5, width of the destination-register tag carried with each request.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  1  EX presents a multiply operation.
- req_ready  output  1  controller can accept a request this cycle.
- req_op  input  2  operation: 00 MUL, 01 MULH, 10 MULHSU, 11 MULHU.
- req_a  input  XLEN  rs1 value.
- req_b  input  XLEN  rs2 value.
- req_tag  input  TAG_W  rd index, returned unchanged.
- flush  input  1  pipeline flush; aborts any operation in flight.
- resp_valid  output  1  result available.
- resp_ready  input  1  writeback accepts the result.
- resp_data  output  XLEN  selected product half.
- resp_tag  output  TAG_W  tag of the completed request.
- busy  output  1  high in CALC and DONE.

Behaviour:
- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, resp_tag=0, busy=0, accumulator=0, cnt=0.
- FSM states:
  - IDLE: req_ready=1. On req_valid && !flush:
    - latch op and tag;
    - latch |a| and |b| (signed interpretation: a for MULH/MULHSU, b for MULH only);
    - latch neg = sign(a_eff) XOR sign(b_eff);
    - clear the 64-bit accumulator and cnt; go to CALC.
  - CALC: req_ready=0. Per cycle, cnt selects the partial product:
    - cnt 0: aL*bL << 0
    - cnt 1: aL*bH << 16
    - cnt 2: aH*bL << 16
    - cnt 3: aH*bH << 32
    - Each partial product is added into the accumulator modulo 2^64.
    - cnt==3 → DONE; the final result is negated (two's complement, 64-bit) when neg=1.
  - DONE: resp_valid=1.
    - resp_data = acc[31:0] for MUL, acc[63:32] otherwise.
    - Hold stable until resp_ready; then go to IDLE.
- Latency: request accepted at edge E0; resp_valid is high after edge E4. Minimum issue interval is 5 cycles with resp_ready tied high.
- req_ready is combinational on state only, never on req_valid.
- Magnitude of 0x80000000 is 0x80000000 as unsigned 32-bit; no overflow special case. MULH 0x80000000*0x80000000 = 0x40000000.
- Flush:
  - Any state → IDLE next edge; resp_valid drops and no response is produced.
  - Flush and req_valid in the same IDLE cycle: the request is not accepted.
  - Flush and resp_ready in DONE together: treated as a flush, not a completed handshake.
- resp_valid never asserts without a preceding accepted request.
- Asynchronous reset mid-operation: immediate return to reset values.

Optional Feature:
- Macro: MUL_ZERO_BYPASS_EN.
- Defined:
  - If either latched magnitude is zero at acceptance, skip CALC and go directly to DONE with result 0 (resp_valid after E1).
  - Other operands unchanged.
- Undefined: all operations take the full 4-cycle CALC.

Decomposition:
- Package mul_pkg holds:
  - op encodings MUL_OP_MUL/MULH/MULHSU/MULHU;
  - FSM state enum (IDLE, CALC, DONE);
  - constant CALC_STEPS=4.
- One sub-module: mul16_u, an unsigned 16x16→32 combinational multiplier, instanced once and reused each CALC cycle via operand muxes.

Test Plan:
- MULHU a=0x40000000 b=0x40000000, resp_ready=1 → resp_valid after E4, data=0x10000000. Repeat as MUL → 0x00000000.
- MULH a=0xFFFFFFFF b=0x00000002 → 0xFFFFFFFF. MUL of the same operands → 0xFFFFFFFE. MULHSU a=0xFFFFFFFF b=0xFFFFFFFF → 0xFFFFFFFF.
- MULH a=0x80000000 b=0x80000000 → 0x40000000; tag 5'd17 returned on resp_tag.
- Back-pressure: resp_ready low 3 cycles in DONE → resp_valid, data and tag stable; req_ready=0 throughout; one response on release.
- Flush at cnt=2 → IDLE next edge, no resp_valid. Flush plus req_valid in IDLE → not accepted, busy stays 0.
- rst_n low during CALC → all outputs at reset values immediately. With MUL_ZERO_BYPASS_EN, a=0 b=0x1234 MUL → data 0 after E1.
